// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding and op codes for the multiply/divide sequencer
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIN  = 3'd3,
        EXC  = 3'd4
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Most negative 32-bit value; INT_MIN / -1 wraps back to INT_MIN.
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - control-side handshake and HI/LO result bundle for multdiv_sequencer
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             divby0flag;
    logic             hilo_write;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, divby0flag, hilo_write, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, divby0flag, hilo_write, hi, lo
    );
endinterface

// File: rtl/multdiv_step.sv
// rtl/multdiv_step.sv - one combinational Booth radix-2 or restoring-division iteration
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_op,
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH:0]   o_acc
);
    // Mult layout: {hi[W], lo[W], q-1}; div layout: {rem[W+1], quotient/dividend[W]}.
    logic [WIDTH:0]   w_hi_ext;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH:0] w_shift;
    logic [WIDTH:0]   w_trial;

    // Booth adds in W+1 bits so an INT_MIN multiplicand cannot corrupt the shifted sign.
    always_comb begin
        w_hi_ext = {i_acc[2*WIDTH], i_acc[2*WIDTH:WIDTH+1]};
        w_m_ext  = {i_operand[WIDTH-1], i_operand};
        w_sum    = w_hi_ext;
        w_shift  = {i_acc[2*WIDTH-1:0], 1'b0};
        w_trial  = w_shift[2*WIDTH:WIDTH] - {1'b0, i_operand};
        o_acc    = i_acc;
        if (i_op == OP_MULT) begin
            case (i_acc[1:0])
                2'b01:   w_sum = w_hi_ext + w_m_ext;
                2'b10:   w_sum = w_hi_ext - w_m_ext;
                default: w_sum = w_hi_ext;
            endcase
            o_acc = {w_sum, i_acc[WIDTH:1]};
        end else if (!w_trial[WIDTH]) begin
            o_acc = {w_trial, w_shift[WIDTH-1:1], 1'b1};
        end else begin
            o_acc = w_shift;
        end
    end
endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - iterative signed mult/div owning HI/LO; MULTDIV_EARLY_TERM_EN enables one-step trivial cases
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset,
    multdiv_if.slave  bus
);
    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [2*WIDTH:0]   w_step_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_early;
    logic               w_early;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

    assign w_abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

`ifdef MULTDIV_EARLY_TERM_EN
    assign w_early = (bus.op == OP_MULT) ? ((bus.a == '0) || (bus.b == '0))
                                         : ((bus.b != '0) && (w_abs_a < w_abs_b));
`else
    assign w_early = 1'b0;
`endif

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .i_op      (r_op),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: start accepted only in IDLE; iterate WIDTH steps unless the early path fires.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.start) begin
                if (bus.op == OP_MULT)  w_next = MULT;
                else if (bus.b == '0)   w_next = EXC;
                else                    w_next = DIV;
            end
            MULT, DIV: if (r_early || (r_cnt == CNT_W'(WIDTH-1))) w_next = FIN;
            FIN, EXC:  w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Final result: Booth product as is, or sign-corrected quotient/remainder.
    assign w_rem = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo = r_acc[WIDTH-1:0];
    always_comb begin
        w_fin_hi = r_acc[2*WIDTH:WIDTH+1];
        w_fin_lo = r_acc[WIDTH:1];
        if (r_op == OP_DIV) begin
            w_fin_hi = r_neg_r ? -w_rem : w_rem;
            w_fin_lo = r_neg_q ? -w_quo : w_quo;
        end
    end

    // Datapath: capture operands on accept, iterate, commit HI/LO in FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_op      <= OP_MULT;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_early   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_cnt   <= '0;
                    r_op    <= bus.op;
                    r_early <= w_early;
                    r_neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    r_neg_r <= bus.a[WIDTH-1];
                    if (bus.op == OP_MULT) begin
                        r_operand <= bus.a;
                        r_acc     <= w_early ? '0 : {{WIDTH{1'b0}}, bus.b, 1'b0};
                    end else begin
                        r_operand <= w_abs_b;
                        r_acc     <= w_early ? {1'b0, w_abs_a, {WIDTH{1'b0}}}
                                             : {{(WIDTH+1){1'b0}}, w_abs_a};
                    end
                end
                MULT, DIV: if (!r_early) begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIN: begin
                    r_hi <= w_fin_hi;
                    r_lo <= w_fin_lo;
                end
                default: ;
            endcase
        end
    end

    // The result is forwarded during FIN so it is readable alongside done.
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == FIN) || (r_state == EXC);
    assign bus.divby0flag = (r_state == EXC);
    assign bus.hilo_write = (r_state == FIN);
    assign bus.hi         = (r_state == FIN) ? w_fin_hi : r_hi;
    assign bus.lo         = (r_state == FIN) ? w_fin_lo : r_lo;
endmodule
